input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_if.sv | 29 ++
 rtl/input_debouncer.sv | 87 ++++++++
 tb/tb_input_debouncer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Switch-debouncer signal bundle: raw switch levels in, debounced levels and change pulses out.
interface input_debouncer_if;
    logic SW_A;
    logic SW_B;
    logic A;
    logic B;
    logic A_EDGE;
    logic B_EDGE;

    // Driver of the raw switch levels, consumer of the debounced outputs
    modport master (
        output SW_A,
        output SW_B,
        input  A,
        input  B,
        input  A_EDGE,
        input  B_EDGE
    );

    // The debouncer itself
    modport slave (
        input  SW_A,
        input  SW_B,
        output A,
        output B,
        output A_EDGE,
        output B_EDGE
    );
endinterface

// File: rtl/input_debouncer.sv
// Two independent switch debouncers: 2-flop synchroniser, then a level is accepted
// only after it differs from the current stable level for CNT_MAX consecutive edges.
module input_debouncer #(
    parameter int unsigned CNT_MAX = 50000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input_debouncer_if.slave   bus
);

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    logic [N_CH-1:0] raw_c;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] pulse;

    assign raw_c = {bus.SW_B, bus.SW_A};

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic             s1_q,     s1_d;
        logic             s2_q,     s2_d;
        logic             stable_q, stable_d;
        logic             edge_q,   edge_d;
        logic [CNT_W-1:0] cnt_q,    cnt_d;
        state_e           state_c;

        // Next-state: IDLE while synchronised input matches the stable level, CHECK counts otherwise
        always_comb begin
            s1_d     = raw_c[ch];
            s2_d     = s1_q;
            stable_d = stable_q;
            edge_d   = 1'b0;
            cnt_d    = '0;
            state_c  = (s2_q == stable_q) ? IDLE : CHECK;
            case (state_c)
                IDLE: begin
                    cnt_d = '0;
                end
                CHECK: begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = ~stable_q;
                        edge_d   = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end

        // Channel state registers; reset clears everything so outputs drop without a clock
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                edge_q   <= 1'b0;
                cnt_q    <= '0;
            end else begin
                s1_q     <= s1_d;
                s2_q     <= s2_d;
                stable_q <= stable_d;
                edge_q   <= edge_d;
                cnt_q    <= cnt_d;
            end
        end

        assign level[ch] = stable_q;
        assign pulse[ch] = edge_q;
    end

    assign bus.A      = level[0];
    assign bus.B      = level[1];
    assign bus.A_EDGE = pulse[0];
    assign bus.B_EDGE = pulse[1];

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with CNT_MAX=4 (change accepted on edge 6 after the input moves).
module tb_input_debouncer;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    typedef struct {
        string      tag;
        logic [3:0] vec;   // {A, B, A_EDGE, B_EDGE}
    } exp_t;

    exp_t exp_q[$];

    input_debouncer_if bus ();

    input_debouncer #(.CNT_MAX(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue n cycles of the same expected output vector
    task automatic expect_n(input string tag, input int n, input logic [3:0] v);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag;
            e.vec = v;
            exp_q.push_back(e);
        end
    endtask

    // Compare the current outputs against the head of the scoreboard
    task automatic check_now();
        exp_t       e;
        logic [3:0] obs;
        e   = exp_q.pop_front();
        obs = {bus.A, bus.B, bus.A_EDGE, bus.B_EDGE};
        n_assert++;
        assert (obs === e.vec) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
        end
    endtask

    // Advance one clock per queued expectation, sampling on the falling edge
    task automatic drain();
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            check_now();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.SW_A   = 1'b0;
        bus.SW_B   = 1'b0;

        // Reset held from time zero
        #2;
        expect_n("rst_async", 1, 4'b0000);
        check_now();
        @(negedge clk);
        expect_n("rst_low", 1, 4'b0000);
        check_now();
        rst_n = 1'b1;
        expect_n("rst_release", 4, 4'b0000);
        drain();

        // Clean press on A, B untouched
        bus.SW_A = 1'b1;
        expect_n("press_wait", 5, 4'b0000);
        expect_n("press_edge", 1, 4'b1010);
        expect_n("press_hold", 4, 4'b1000);
        drain();

        // Release of A
        bus.SW_A = 1'b0;
        expect_n("rel_wait", 5, 4'b1000);
        expect_n("rel_edge", 1, 4'b0010);
        expect_n("rel_hold", 3, 4'b0000);
        drain();

        // Bounce: high 3, low 1, then high held
        bus.SW_A = 1'b1;
        expect_n("bnc_hi", 3, 4'b0000);
        drain();
        bus.SW_A = 1'b0;
        expect_n("bnc_lo", 1, 4'b0000);
        drain();
        bus.SW_A = 1'b1;
        expect_n("bnc_wait", 5, 4'b0000);
        expect_n("bnc_edge", 1, 4'b1010);
        expect_n("bnc_hold", 3, 4'b1000);
        drain();
        bus.SW_A = 1'b0;
        expect_n("bnc_rel_wait", 5, 4'b1000);
        expect_n("bnc_rel_edge", 1, 4'b0010);
        expect_n("bnc_rel_hold", 2, 4'b0000);
        drain();

        // Glitch on B: high 3 cycles then low
        bus.SW_B = 1'b1;
        expect_n("glitch_hi", 3, 4'b0000);
        drain();
        bus.SW_B = 1'b0;
        expect_n("glitch_lo", 8, 4'b0000);
        drain();

        // Fast toggling on A every 2 cycles never qualifies
        for (int i = 0; i < 8; i++) begin
            bus.SW_A = ~bus.SW_A;
            expect_n("fast_toggle", 2, 4'b0000);
            drain();
        end
        expect_n("fast_settle", 6, 4'b0000);
        drain();

        // Simultaneous press and release on both channels
        bus.SW_A = 1'b1;
        bus.SW_B = 1'b1;
        expect_n("sim_wait", 5, 4'b0000);
        expect_n("sim_edge", 1, 4'b1111);
        expect_n("sim_hold", 2, 4'b1100);
        drain();
        bus.SW_A = 1'b0;
        bus.SW_B = 1'b0;
        expect_n("sim_rel_wait", 5, 4'b1100);
        expect_n("sim_rel_edge", 1, 4'b0011);
        expect_n("sim_rel_hold", 2, 4'b0000);
        drain();

        // Bring both high again, then assert reset asynchronously mid-cycle
        bus.SW_A = 1'b1;
        bus.SW_B = 1'b1;
        expect_n("pre_rst_wait", 5, 4'b0000);
        expect_n("pre_rst_edge", 1, 4'b1111);
        expect_n("pre_rst_hold", 2, 4'b1100);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        expect_n("rst_mid_async", 1, 4'b0000);
        check_now();
        @(negedge clk);
        expect_n("rst_mid_held", 1, 4'b0000);
        check_now();
        bus.SW_A = 1'b0;
        bus.SW_B = 1'b0;
        rst_n    = 1'b1;
        expect_n("rst_mid_quiet", 6, 4'b0000);
        drain();

        // Reset during a count discards it; a full fresh count follows release
        bus.SW_A = 1'b1;
        expect_n("cnt_rst_pre", 4, 4'b0000);
        drain();
        rst_n = 1'b0;
        #1;
        expect_n("cnt_rst_async", 1, 4'b0000);
        check_now();
        @(negedge clk);
        expect_n("cnt_rst_held", 1, 4'b0000);
        check_now();
        rst_n = 1'b1;
        expect_n("cnt_rst_wait", 5, 4'b0000);
        expect_n("cnt_rst_edge", 1, 4'b1010);
        expect_n("cnt_rst_hold", 2, 4'b1000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
